// File: rtl/axi4_stream_to_video_if.sv
// AXI4-Stream channel carrying one video pixel per beat.
// tuser marks the first pixel of a frame and tlast marks the last pixel of a line.
interface axi4_stream_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axi4_stream_to_video.sv
// Converts an AXI4-Stream pixel stream into free-running video timing.
// The timing generator never stalls; the stream is only read while aligned to it.
module axi4_stream_to_video #(
    parameter int FRAME_RES_X = 1920,
    parameter int FRAME_RES_Y = 1080,
    parameter int H_FP        = 88,
    parameter int H_SYNC      = 44,
    parameter int H_BP        = 148,
    parameter int V_FP        = 4,
    parameter int V_SYNC      = 5,
    parameter int V_BP        = 36,
    parameter bit SYNC_POL    = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    axi4_stream_if.slave video_i,
    output logic [15:0]  px_data_o,
    output logic         de_o,
    output logic         hsync_o,
    output logic         vsync_o,
    output logic         locked_o,
    output logic         underflow_o
);
    localparam int H_TOTAL = FRAME_RES_X + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = FRAME_RES_Y + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT        = HW'(FRAME_RES_X);
    localparam logic [HW-1:0] H_ACT_LAST   = HW'(FRAME_RES_X - 1);
    localparam logic [HW-1:0] H_SYNC_START = HW'(FRAME_RES_X + H_FP);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(FRAME_RES_X + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT        = VW'(FRAME_RES_Y);
    localparam logic [VW-1:0] V_SYNC_START = VW'(FRAME_RES_Y + V_FP);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(FRAME_RES_Y + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {SEEK, WAIT_START, LOCKED} state_t;

    state_t          state_q;
    logic [HW-1:0]   h_cnt_q, h_cnt_d;
    logic [VW-1:0]   v_cnt_q, v_cnt_d;
    logic [15:0]     px_data_q;
    logic            de_q, hsync_q, vsync_q, locked_q, underflow_q;

    logic            h_wrap, v_wrap, at_origin, active, lock_err, tready;

    always_comb begin
        h_wrap    = (h_cnt_q == H_LAST);
        v_wrap    = (v_cnt_q == V_LAST);
        h_cnt_d   = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d   = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
        end
        at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
        active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        lock_err  = 1'b0;
        tready    = 1'b0;
        // A rejected word is never consumed, so a pending SOF survives to relock.
        if (!rst_i) begin
            case (state_q)
                SEEK:       tready = !(video_i.tvalid && video_i.tuser);
                WAIT_START: tready = 1'b0;
                LOCKED: begin
                    lock_err = active && (!video_i.tvalid
                                          || (video_i.tuser != at_origin)
                                          || (video_i.tlast != (h_cnt_q == H_ACT_LAST)));
                    tready   = active && !lock_err;
                end
                default:    tready = 1'b0;
            endcase
        end
    end

    assign video_i.tready = tready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            state_q     <= SEEK;
            px_data_q   <= '0;
            de_q        <= 1'b0;
            hsync_q     <= !SYNC_POL;
            vsync_q     <= !SYNC_POL;
            locked_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            de_q        <= active;
            hsync_q     <= (h_cnt_q >= H_SYNC_START && h_cnt_q <= H_SYNC_END) ? SYNC_POL : !SYNC_POL;
            vsync_q     <= (v_cnt_q >= V_SYNC_START && v_cnt_q <= V_SYNC_END) ? SYNC_POL : !SYNC_POL;
            locked_q    <= (state_q == LOCKED);
            underflow_q <= lock_err;
            px_data_q   <= (state_q == LOCKED && tready && video_i.tvalid) ? video_i.tdata : '0;
            // Lock is entered on the clock that wraps the counters back to the frame origin.
            case (state_q)
                SEEK:       if (video_i.tvalid && video_i.tuser) state_q <= WAIT_START;
                WAIT_START: if (h_wrap && v_wrap) state_q <= LOCKED;
                LOCKED:     if (lock_err) state_q <= SEEK;
                default:    state_q <= SEEK;
            endcase
        end
    end

    assign px_data_o   = px_data_q;
    assign de_o        = de_q;
    assign hsync_o     = hsync_q;
    assign vsync_o     = vsync_q;
    assign locked_o    = locked_q;
    assign underflow_o = underflow_q;
endmodule

// File: tb/tb_axi4_stream_to_video.sv
// Scoreboard bench for axi4_stream_to_video on a tiny 4x2 raster.
// A frame-position reference model predicts every cycle; a monitor compares at negedge.
module tb_axi4_stream_to_video;
    localparam int RES_X = 4;
    localparam int RES_Y = 2;
    localparam int HFP   = 1;
    localparam int HSYNC = 2;
    localparam int HBP   = 1;
    localparam int VFP   = 1;
    localparam int VSYNC = 1;
    localparam int VBP   = 1;
    localparam int HTOT  = RES_X + HFP + HSYNC + HBP;
    localparam int VTOT  = RES_Y + VFP + VSYNC + VBP;
    localparam int FTOT  = HTOT * VTOT;
    localparam bit POL   = 1'b1;

    typedef struct packed {
        logic [15:0] px;
        logic        de;
        logic        hs;
        logic        vs;
        logic        lk;
        logic        uf;
    } regs_t;

    typedef struct packed {
        logic  ready;
        regs_t r;
    } exp_t;

    typedef struct packed {
        logic [15:0] data;
        logic        user;
        logic        last;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] pxData;
    logic deOut, hsOut, vsOut, lkOut, ufOut;

    axi4_stream_if #(.DATA_W(16)) vid ();

    axi4_stream_to_video #(
        .FRAME_RES_X(RES_X), .FRAME_RES_Y(RES_Y),
        .H_FP(HFP), .H_SYNC(HSYNC), .H_BP(HBP),
        .V_FP(VFP), .V_SYNC(VSYNC), .V_BP(VBP),
        .SYNC_POL(POL)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .video_i(vid),
        .px_data_o(pxData),
        .de_o(deOut),
        .hsync_o(hsOut),
        .vsync_o(vsOut),
        .locked_o(lkOut),
        .underflow_o(ufOut)
    );

    always #5 clk = ~clk;

    exp_t  sbQ[$];
    word_t srcQ[$];
    int    checks = 0;
    int    errors = 0;
    int    t = 0;
    int    lockStart = -1;
    regs_t prevRegs;
    bit    haveRegs = 1'b0;
    int    gapPct = 0;
    bit    dropArmed = 1'b0;
    int    dropH = 0;
    int    dropV = 0;

    // Monitor: compares tready and the registered outputs against the oldest prediction.
    task automatic checkOutput(input exp_t e);
        regs_t a;
        a.px = pxData;
        a.de = deOut;
        a.hs = hsOut;
        a.vs = vsOut;
        a.lk = lkOut;
        a.uf = ufOut;
        checks++;
        if (vid.tready !== e.ready || a !== e.r) begin
            errors++;
            $display("[TB] FAIL cycle@%0t got rdy=%b px=%04h de=%b hs=%b vs=%b lk=%b uf=%b required rdy=%b px=%04h de=%b hs=%b vs=%b lk=%b uf=%b",
                     $time, vid.tready, a.px, a.de, a.hs, a.vs, a.lk, a.uf,
                     e.ready, e.r.px, e.r.de, e.r.hs, e.r.vs, e.r.lk, e.r.uf);
        end
    endtask

    always @(negedge clk) begin
        if (sbQ.size() != 0) checkOutput(sbQ.pop_front());
    end

    // Frame kinds: 0 clean, 1 stray tlast on pixel 2, 2 truncated so the next SOF comes early.
    task automatic pushFrame(input int kind, input bit seq);
        word_t w;
        int n;
        n = (kind == 2) ? 5 : RES_X * RES_Y;
        for (int i = 0; i < n; i++) begin
            w.data = seq ? 16'(i + 1) : 16'($urandom);
            w.user = (i == 0);
            w.last = ((i % RES_X) == RES_X - 1) || (kind == 1 && i == 2);
            srcQ.push_back(w);
        end
    endtask

    // One clock: drive the bus, advance the model, queue the prediction for the monitor.
    task automatic applyStimulus(input bit doReset);
        int    h, v;
        bit    active, isLocked, isWaiting, origin, err, ready, valid;
        word_t w;
        regs_t nr;
        @(posedge clk);
        #1;
        h = t % HTOT;
        v = (t / HTOT) % VTOT;
        isLocked  = (lockStart >= 0) && (t >= lockStart);
        isWaiting = (lockStart >= 0) && (t < lockStart);
        valid = (srcQ.size() != 0);
        if (valid && gapPct != 0 && $urandom_range(99) < gapPct) valid = 1'b0;
        if (!doReset && dropArmed && isLocked && h == dropH && v == dropV) begin
            valid = 1'b0;
            dropArmed = 1'b0;
        end
        if (valid) w = srcQ[0];
        else begin
            w.data = 16'($urandom);
            w.user = 1'($urandom);
            w.last = 1'($urandom);
        end
        rst        = doReset;
        vid.tvalid = valid;
        vid.tdata  = w.data;
        vid.tuser  = w.user;
        vid.tlast  = w.last;

        if (doReset) begin
            ready = 1'b0;
            nr = '{px: 16'h0, de: 1'b0, hs: !POL, vs: !POL, lk: 1'b0, uf: 1'b0};
            t = 0;
            lockStart = -1;
        end else begin
            active = (h < RES_X) && (v < RES_Y);
            origin = (h == 0) && (v == 0);
            err    = 1'b0;
            nr.px  = 16'h0;
            if (isLocked) begin
                err   = active && (!valid || (w.user != origin) || (w.last != (h == RES_X - 1)));
                ready = active && !err;
                if (ready) nr.px = w.data;
                if (err) lockStart = -1;
            end else if (isWaiting) begin
                ready = 1'b0;
            end else begin
                ready = !(valid && w.user);
                if (valid && w.user) lockStart = ((t + 1) / FTOT + 1) * FTOT;
            end
            nr.de = active;
            nr.hs = (h >= RES_X + HFP && h < RES_X + HFP + HSYNC) ? POL : !POL;
            nr.vs = (v >= RES_Y + VFP && v < RES_Y + VFP + VSYNC) ? POL : !POL;
            nr.lk = isLocked;
            nr.uf = err;
            if (valid && ready) void'(srcQ.pop_front());
            t++;
        end
        if (haveRegs) sbQ.push_back('{ready: ready, r: prevRegs});
        prevRegs = nr;
        haveRegs = 1'b1;
    endtask

    // mode 0: no refill, 1: sequential 1..8 frames, 2: random frames with occasional corruption
    task automatic runCycles(input int n, input int mode);
        int r;
        for (int i = 0; i < n; i++) begin
            if (mode != 0 && srcQ.size() < 16) begin
                if (mode == 1) pushFrame(0, 1'b1);
                else begin
                    r = $urandom_range(9);
                    pushFrame((r < 8) ? 0 : ((r == 8) ? 1 : 2), 1'b0);
                end
            end
            applyStimulus(1'b0);
        end
    endtask

    initial begin
        word_t g;
        vid.tvalid = 1'b0;
        vid.tdata  = 16'h0;
        vid.tuser  = 1'b0;
        vid.tlast  = 1'b0;
        repeat (3) applyStimulus(1'b1);

        runCycles(2 * FTOT, 0);

        for (int i = 0; i < 5; i++) begin
            g.data = 16'($urandom);
            g.user = 1'b0;
            g.last = 1'($urandom);
            srcQ.push_back(g);
        end
        runCycles(4 * FTOT, 1);

        dropH = 2;
        dropV = 1;
        dropArmed = 1'b1;
        runCycles(4 * FTOT, 1);

        pushFrame(1, 1'b0);
        runCycles(4 * FTOT, 1);

        pushFrame(2, 1'b0);
        runCycles(4 * FTOT, 1);

        for (int i = 0; i < 3 * FTOT; i++) begin
            if (lockStart >= 0 && t >= lockStart && (t % HTOT) == 2 && ((t / HTOT) % VTOT) == 0) break;
            runCycles(1, 1);
        end
        applyStimulus(1'b1);
        runCycles(4 * FTOT, 1);

        gapPct = 3;
        runCycles(25 * FTOT, 2);
        gapPct = 0;
        runCycles(2 * FTOT, 2);

        repeat (3) @(negedge clk);
        if (sbQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain pending=%0d required=0", sbQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi4_stream_to_video.md
AXI4_STREAM_TO_VIDEO -- requirements
Module: axi4_stream_to_video

Interface
REQ-001 Parameter FRAME_RES_X, default 1920, active pixels per line.
REQ-002 Parameter FRAME_RES_Y, default 1080, active lines per frame.
REQ-003 Parameters H_FP, H_SYNC, H_BP, defaults 88, 44, 148: horizontal front porch, sync and back porch, in clocks.
REQ-004 Parameters V_FP, V_SYNC, V_BP, defaults 4, 5, 36: vertical front porch, sync and back porch, in lines.
REQ-005 Parameter SYNC_POL, default 1: hsync_o/vsync_o asserted level.
REQ-006 Port clk_i, input, 1: single clock; all logic on rising edge.
REQ-007 Port rst_i, input, 1: reset, synchronous, active-high.
REQ-008 Port video_i, axi4_stream_if.slave, TDATA 16: one pixel per word; tuser = start of frame; tlast = end of line.
REQ-009 Port px_data_o, output, 16: pixel data.
REQ-010 Port de_o, output, 1: data enable.
REQ-011 Port hsync_o / vsync_o, output, 1 each: sync pulses.
REQ-012 Port locked_o, output, 1: high while aligned to the input frame.
REQ-013 Port underflow_o, output, 1: one-clock pulse on loss of lock.

Function
REQ-014 H_TOTAL = FRAME_RES_X+H_FP+H_SYNC+H_BP; V_TOTAL = FRAME_RES_Y+V_FP+V_SYNC+V_BP; counter widths $clog2 of each total.
REQ-015 h_cnt free-runs 0..H_TOTAL-1 and wraps to 0; v_cnt increments on h_cnt wrap and wraps at V_TOTAL-1 to 0.
REQ-016 Line order: active (h_cnt < FRAME_RES_X), front porch, sync, back porch. Frame order in lines: active, V_FP, V_SYNC, V_BP.
REQ-017 The active window is h_cnt < FRAME_RES_X and v_cnt < FRAME_RES_Y.
REQ-018 hsync_o = SYNC_POL while h_cnt is in [RES_X+H_FP, RES_X+H_FP+H_SYNC-1]; vsync_o uses the same rule on v_cnt for the whole line.
REQ-019 Every output is registered with 1-clock latency from its counter state; px_data_o, de_o, hsync_o and vsync_o stay mutually aligned.
REQ-020 FSM states: SEEK, WAIT_START, LOCKED.
REQ-021 In SEEK: tready = 1; every word without tuser is dropped; a valid word with tuser is not consumed (tready low in that cycle) and the FSM moves to WAIT_START.
REQ-022 In WAIT_START: tready = 0; at h_cnt = 0 and v_cnt = 0 the FSM moves to LOCKED.
REQ-023 In LOCKED: tready = the active-window flag; on each handshake px_data_o <= tdata.
REQ-024 de_o = 1 exactly in the active window in every state, so timing never stops; px_data_o = 0 whenever de_o = 0 or no handshake occurred.
REQ-025 Loss of lock is detected in LOCKED:
  - tvalid = 0 inside the active window;
  - tuser = 1 on a word not at (0,0);
  - tuser = 0 at (0,0);
  - tlast not matching h_cnt = FRAME_RES_X-1.
REQ-026 On loss of lock: underflow_o pulses for 1 clock; the offending word is not consumed; the FSM moves to SEEK; remaining active pixels of that frame output 0 with de_o = 1.
REQ-027 locked_o = 1 only in LOCKED, registered (1-clock latency).
REQ-028 If a loss-of-lock condition coincides with counter wrap to (0,0) while the word is a valid SOF, the condition still applies and the FSM still goes to SEEK; there is no shortcut relock.

Reset
REQ-029 While rst_i = 1: h_cnt = 0, v_cnt = 0, FSM = SEEK, tready = 0, px_data_o = 0, de_o = 0, hsync_o = vsync_o = !SYNC_POL, locked_o = 0, underflow_o = 0.
REQ-030 Reset asserted mid-frame takes effect on the next edge; partially read lines are discarded; after release the block restarts from h_cnt = 0, v_cnt = 0 in SEEK.

Verification
Bench parameters: RES_X = 4, RES_Y = 2, H_FP = 1, H_SYNC = 2, H_BP = 1, V_FP = 1, V_SYNC = 1, V_BP = 1 (H_TOTAL = 8, V_TOTAL = 5).
REQ-031 Reset, no input -> de_o high 4 of every 8 clocks on lines 0-1 only; hsync_o at h_cnt 5-6; vsync_o for all of line 3; px_data_o = 0; locked_o = 0.
REQ-032 Continuous frames 0x0001..0x0008 with tuser on the first word and tlast on every 4th word -> locked_o rises within one frame; each active line outputs the matching pixels with de_o; underflow_o never pulses.
REQ-033 Garbage words before the first SOF -> all garbage dropped with tready = 1; first output pixel is the SOF word at (0,0).
REQ-034 tvalid dropped for 1 clock at pixel 2 of line 1 -> underflow_o pulses once; px_data_o = 0 for the rest of that line; locked_o falls; relock on the next SOF.
REQ-035 tlast on pixel 2 -> loss of lock and underflow pulse; SOF at the wrong position -> same response, and that SOF word is used for relock.
REQ-036 rst_i for 1 clock in mid-line while LOCKED -> all outputs take reset values; normal relock follows.
